al4s3b_counter_bank: RTL and testbench

//  Parametrised successor to the single 32-bit fabric counter: NUM_CH independent counters, each
//  CNT_WIDTH bits, in one Wishbone-slave register block behind the AHB-to-FPGA bridge.
//  Per-channel up/down direction, wrap-with-reload or one-shot mode, compare match, sticky W1C

---
 rtl/al4s3b_counter_bank_pkg.sv | 42 ++++
 rtl/al4s3b_counter_bank_if.sv | 24 ++
 rtl/al4s3b_counter_ch.sv | 94 +++++++++
 rtl/al4s3b_counter_bank.sv | 130 +++++++++++++
 tb/tb_al4s3b_counter_bank.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/al4s3b_counter_bank_pkg.sv
// rtl/al4s3b_counter_bank_pkg.sv - register map constants and field positions for the counter bank
package al4s3b_counter_bank_pkg;

   // Word addresses of the bank-level registers
   localparam int ADR_ID     = 'h00;
   localparam int ADR_STATUS = 'h01;
   localparam int ADR_IRQ_EN = 'h02;

   // Channel c occupies CH_BASE + CH_STRIDE*c .. +3
   localparam int CH_BASE   = 'h10;
   localparam int CH_STRIDE = 4;

   // CTRL bit positions
   localparam int CTRL_EN      = 0;
   localparam int CTRL_DIR     = 1;
   localparam int CTRL_ONESHOT = 2;
   localparam int CTRL_CLR     = 3;

   // STATUS / IRQ_EN layout: overflow flags from bit 0, match flags from bit 8
   localparam int STAT_OVF_BASE   = 0;
   localparam int STAT_MATCH_BASE = 8;
   localparam int STAT_WIDTH      = 16;

   typedef enum logic [1:0] {
      REG_CTRL    = 2'd0,
      REG_RELOAD  = 2'd1,
      REG_COMPARE = 2'd2,
      REG_VALUE   = 2'd3
   } ch_reg_e;

   // Bits of STATUS/IRQ_EN that exist for a given channel count
   function automatic logic [STAT_WIDTH-1:0] stat_mask(input int num_ch);
      logic [STAT_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < num_ch; i++) begin
         m[STAT_OVF_BASE + i]   = 1'b1;
         m[STAT_MATCH_BASE + i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/al4s3b_counter_bank_if.sv
// rtl/al4s3b_counter_bank_if.sv - Wishbone slave bundle for the counter bank
interface al4s3b_counter_bank_if #(
   parameter int ADDRWIDTH = 7,
   parameter int DATAWIDTH = 32
);
   logic [ADDRWIDTH-1:0] WBs_ADR;
   logic                 WBs_CYC;
   logic                 WBs_STB;
   logic                 WBs_WE;
   logic [3:0]           WBs_BYTE_STB;
   logic [DATAWIDTH-1:0] WBs_WR_DAT;
   logic [DATAWIDTH-1:0] WBs_RD_DAT;
   logic                 WBs_ACK;

   modport master (
      output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT,
      input  WBs_RD_DAT, WBs_ACK
   );

   modport slave (
      input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT,
      output WBs_RD_DAT, WBs_ACK
   );
endinterface

// File: rtl/al4s3b_counter_ch.sv
// rtl/al4s3b_counter_ch.sv - one counter channel: count, control, reload, compare, terminal/match detect
module al4s3b_counter_ch
   import al4s3b_counter_bank_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_wr_ctrl,
   input  logic                 i_wr_reload,
   input  logic                 i_wr_compare,
   input  logic                 i_wr_value,
   input  logic [CNT_WIDTH-1:0] i_wdata,
   output logic [CNT_WIDTH-1:0] o_cnt,
   output logic [CNT_WIDTH-1:0] o_reload,
   output logic [CNT_WIDTH-1:0] o_compare,
   output logic [2:0]           o_ctrl,
   output logic                 o_ovf_hit,
   output logic                 o_match_hit,
   output logic                 o_match_pulse
);
   logic [CNT_WIDTH-1:0] r_cnt, r_reload, r_compare, w_cnt_nxt;
   logic [2:0]           r_ctrl;
   logic                 r_match_pulse;
   logic                 w_en, w_dir, w_oneshot, w_term, w_clr;

   assign w_en      = r_ctrl[CTRL_EN];
   assign w_dir     = r_ctrl[CTRL_DIR];
   assign w_oneshot = r_ctrl[CTRL_ONESHOT];
   assign w_clr     = i_wr_ctrl & i_wdata[CTRL_CLR];
   assign w_term    = w_dir ? (r_cnt == '0) : (r_cnt == '1);

   // Terminal and match flags come from the registered state, independent of a
   // concurrent CLR/VALUE write, so a collision still reports the event.
   assign o_ovf_hit   = w_en & w_term;
   assign o_match_hit = w_en & (r_cnt == r_compare);

   // Next count: CLR beats VALUE load beats counting
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_clr) begin
         w_cnt_nxt = '0;
      end else if (i_wr_value) begin
         w_cnt_nxt = i_wdata;
      end else if (w_en) begin
         if (w_term) begin
            w_cnt_nxt = w_oneshot ? r_cnt : r_reload;
         end else if (w_dir) begin
            w_cnt_nxt = r_cnt - 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   // Counter register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   // Configuration registers; one-shot drops EN at terminal unless the bus rewrites CTRL
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ctrl        <= '0;
         r_reload      <= '0;
         r_compare     <= '0;
         r_match_pulse <= 1'b0;
      end else begin
         if (i_wr_ctrl) begin
            r_ctrl <= i_wdata[CTRL_ONESHOT:CTRL_EN];
         end else if (o_ovf_hit && w_oneshot) begin
            r_ctrl[CTRL_EN] <= 1'b0;
         end
         if (i_wr_reload) begin
            r_reload <= i_wdata;
         end
         if (i_wr_compare) begin
            r_compare <= i_wdata;
         end
         r_match_pulse <= o_match_hit;
      end
   end

   assign o_cnt         = r_cnt;
   assign o_reload      = r_reload;
   assign o_compare     = r_compare;
   assign o_ctrl        = r_ctrl;
   assign o_match_pulse = r_match_pulse;

endmodule

// File: rtl/al4s3b_counter_bank.sv
// rtl/al4s3b_counter_bank.sv - Wishbone register block wrapping NUM_CH counter channels
module al4s3b_counter_bank
   import al4s3b_counter_bank_pkg::*;
#(
   parameter int          NUM_CH             = 4,
   parameter int          CNT_WIDTH          = 32,
   parameter int          ADDRWIDTH          = 7,
   parameter int          DATAWIDTH          = 32,
   parameter logic [31:0] BANK_ID            = 32'hC0B4_0001,
   parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADF_ABAC
) (
   input  logic                        WB_CLK,
   input  logic                        WB_RST,
   al4s3b_counter_bank_if.slave        wb,
   output logic [NUM_CH*CNT_WIDTH-1:0] count,
   output logic [NUM_CH-1:0]           match_pulse,
   output logic                        irq
);
   localparam logic [STAT_WIDTH-1:0] STAT_MASK = stat_mask(NUM_CH);

   logic                  w_req, w_wr, w_adr_status, w_adr_irq_en;
   ch_reg_e               w_off;
   logic [DATAWIDTH-1:0]  w_bmask, w_rd_val, w_merged;
   logic [NUM_CH-1:0]     w_ch_sel, w_ovf_hit, w_match_hit;
   logic [2:0]            w_ctrl    [NUM_CH];
   logic [CNT_WIDTH-1:0]  w_cnt     [NUM_CH];
   logic [CNT_WIDTH-1:0]  w_reload  [NUM_CH];
   logic [CNT_WIDTH-1:0]  w_compare [NUM_CH];
   logic [STAT_WIDTH-1:0] w_stat_set, w_stat_clr;
   logic                  r_ack;
   logic [DATAWIDTH-1:0]  r_rd_dat;
   logic [STAT_WIDTH-1:0] r_status, r_irq_en;

   assign w_req        = wb.WBs_CYC & wb.WBs_STB;
   assign w_wr         = r_ack & w_req & wb.WBs_WE;
   assign w_off        = ch_reg_e'(wb.WBs_ADR[1:0]);
   assign w_adr_status = (wb.WBs_ADR == ADDRWIDTH'(ADR_STATUS));
   assign w_adr_irq_en = (wb.WBs_ADR == ADDRWIDTH'(ADR_IRQ_EN));
   assign w_bmask      = {{8{wb.WBs_BYTE_STB[3]}}, {8{wb.WBs_BYTE_STB[2]}},
                          {8{wb.WBs_BYTE_STB[1]}}, {8{wb.WBs_BYTE_STB[0]}}};
   // Unstrobed lanes keep the register's current contents
   assign w_merged     = (wb.WBs_WR_DAT & w_bmask) | (w_rd_val & ~w_bmask);
   assign w_stat_clr   = (w_wr && w_adr_status) ?
                         (wb.WBs_WR_DAT[STAT_WIDTH-1:0] & w_bmask[STAT_WIDTH-1:0]) : '0;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_ch_sel[g] = (wb.WBs_ADR[ADDRWIDTH-1:2] == (ADDRWIDTH-2)'(CH_BASE / CH_STRIDE + g));

      al4s3b_counter_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
         .i_clk         (WB_CLK),
         .i_rst_n       (WB_RST),
         .i_wr_ctrl     (w_wr & w_ch_sel[g] & (w_off == REG_CTRL)),
         .i_wr_reload   (w_wr & w_ch_sel[g] & (w_off == REG_RELOAD)),
         .i_wr_compare  (w_wr & w_ch_sel[g] & (w_off == REG_COMPARE)),
         .i_wr_value    (w_wr & w_ch_sel[g] & (w_off == REG_VALUE)),
         .i_wdata       (w_merged[CNT_WIDTH-1:0]),
         .o_cnt         (w_cnt[g]),
         .o_reload      (w_reload[g]),
         .o_compare     (w_compare[g]),
         .o_ctrl        (w_ctrl[g]),
         .o_ovf_hit     (w_ovf_hit[g]),
         .o_match_hit   (w_match_hit[g]),
         .o_match_pulse (match_pulse[g])
      );

      assign count[g*CNT_WIDTH +: CNT_WIDTH] = w_cnt[g];
   end

   // Read mux; anything not decoded returns the default pattern
   always_comb begin
      w_rd_val = DEFAULT_READ_VALUE;
      if (wb.WBs_ADR == ADDRWIDTH'(ADR_ID)) begin
         w_rd_val = BANK_ID;
      end else if (w_adr_status) begin
         w_rd_val = DATAWIDTH'(r_status);
      end else if (w_adr_irq_en) begin
         w_rd_val = DATAWIDTH'(r_irq_en);
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_ch_sel[i]) begin
            case (w_off)
               REG_CTRL:    w_rd_val = DATAWIDTH'(w_ctrl[i]);
               REG_RELOAD:  w_rd_val = DATAWIDTH'(w_reload[i]);
               REG_COMPARE: w_rd_val = DATAWIDTH'(w_compare[i]);
               REG_VALUE:   w_rd_val = DATAWIDTH'(w_cnt[i]);
            endcase
         end
      end
   end

   // Gather per-channel events into the STATUS layout
   always_comb begin
      w_stat_set = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_stat_set[STAT_OVF_BASE + i]   = w_ovf_hit[i];
         w_stat_set[STAT_MATCH_BASE + i] = w_match_hit[i];
      end
   end

   // Single-cycle ACK with read data captured alongside it
   always_ff @(posedge WB_CLK or negedge WB_RST) begin
      if (!WB_RST) begin
         r_ack    <= 1'b0;
         r_rd_dat <= '0;
      end else begin
         r_ack <= w_req & ~r_ack;
         if (w_req && !r_ack) begin
            r_rd_dat <= w_rd_val;
         end
      end
   end

   // Sticky status (a new event beats a same-cycle W1C) and interrupt enables
   always_ff @(posedge WB_CLK or negedge WB_RST) begin
      if (!WB_RST) begin
         r_status <= '0;
         r_irq_en <= '0;
      end else begin
         r_status <= ((r_status & ~w_stat_clr) | w_stat_set) & STAT_MASK;
         if (w_wr && w_adr_irq_en) begin
            r_irq_en <= w_merged[STAT_WIDTH-1:0] & STAT_MASK;
         end
      end
   end

   assign wb.WBs_ACK    = r_ack;
   assign wb.WBs_RD_DAT = r_rd_dat;
   assign irq           = |(r_status & r_irq_en);

endmodule

// File: tb/tb_al4s3b_counter_bank.sv
// tb/tb_al4s3b_counter_bank.sv - directed table and sequence checks for the counter bank
module tb_al4s3b_counter_bank;

   typedef struct {
      logic        we;
      logic [6:0]  adr;
      logic [31:0] dat;
      logic [3:0]  stb;
      logic [31:0] exp;
      logic        exp_irq;
   } vec_t;

   logic clk = 1'b0;
   logic rst1, rst2;
   logic [127:0] cnt1;
   logic [15:0]  cnt2;
   logic [3:0]   mp1;
   logic [1:0]   mp2;
   logic         irq1, irq2;
   int checks = 0;
   int errors = 0;
   vec_t vt [21];

   always #5 clk = ~clk;

   al4s3b_counter_bank_if #(.ADDRWIDTH(7), .DATAWIDTH(32)) bif1 ();
   al4s3b_counter_bank_if #(.ADDRWIDTH(7), .DATAWIDTH(32)) bif2 ();

   al4s3b_counter_bank dut1 (
      .WB_CLK(clk), .WB_RST(rst1), .wb(bif1),
      .count(cnt1), .match_pulse(mp1), .irq(irq1)
   );

   al4s3b_counter_bank #(.NUM_CH(2), .CNT_WIDTH(8)) dut2 (
      .WB_CLK(clk), .WB_RST(rst2), .wb(bif2),
      .count(cnt2), .match_pulse(mp2), .irq(irq2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic cyc, input logic we, input logic [6:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      if (sel) begin
         bif2.WBs_CYC = cyc; bif2.WBs_STB = cyc; bif2.WBs_WE = we;
         bif2.WBs_ADR = a; bif2.WBs_WR_DAT = d; bif2.WBs_BYTE_STB = s;
      end else begin
         bif1.WBs_CYC = cyc; bif1.WBs_STB = cyc; bif1.WBs_WE = we;
         bif1.WBs_ADR = a; bif1.WBs_WR_DAT = d; bif1.WBs_BYTE_STB = s;
      end
   endtask

   function automatic logic ack_of(input bit sel);
      return sel ? bif2.WBs_ACK : bif1.WBs_ACK;
   endfunction

   function automatic logic [31:0] rd_of(input bit sel);
      return sel ? bif2.WBs_RD_DAT : bif1.WBs_RD_DAT;
   endfunction

   // Called at a negedge; returns at the negedge just after the commit edge
   task automatic bus(input bit sel, input logic we, input logic [6:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
      int n;
      drive(sel, 1'b1, we, a, d, s);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack_of(sel) && n < 10);
      chk("ack_seen", {31'b0, ack_of(sel)}, 32'h1);
      rd = rd_of(sel);
      @(negedge clk);
      chk("ack_one_cycle", {31'b0, ack_of(sel)}, 32'h0);
      drive(sel, 1'b0, 1'b0, 7'h0, 32'h0, 4'h0);
   endtask

   task automatic wr(input bit sel, input logic [6:0] a, input logic [31:0] d);
      logic [31:0] rd;
      bus(sel, 1'b1, a, d, 4'hF, rd);
   endtask

   task automatic rdchk(input bit sel, input logic [6:0] a, input logic [31:0] exp, input string name);
      logic [31:0] rd;
      bus(sel, 1'b0, a, 32'h0, 4'hF, rd);
      chk(name, rd, exp);
   endtask

   task automatic run_vecs(input int lo, input int hi);
      logic [31:0] rd;
      for (int i = lo; i < hi; i++) begin
         bus(1'b0, vt[i].we, vt[i].adr, vt[i].dat, vt[i].stb, rd);
         if (!vt[i].we) chk($sformatf("vec%0d_rd", i), rd, vt[i].exp);
         chk($sformatf("vec%0d_irq", i), {31'b0, irq1}, {31'b0, vt[i].exp_irq});
      end
   endtask

   initial begin
      int pulses;
      logic [31:0] at;
      logic [31:0] seq3 [5];

      //            we    adr    dat            stb   exp            irq
      vt[0]  = '{1'b0, 7'h00, 32'h0,         4'hF, 32'hC0B4_0001, 1'b0};
      vt[1]  = '{1'b0, 7'h13, 32'h0,         4'hF, 32'h0,         1'b0};
      vt[2]  = '{1'b0, 7'h7F, 32'h0,         4'hF, 32'hBADF_ABAC, 1'b0};
      vt[3]  = '{1'b0, 7'h03, 32'h0,         4'hF, 32'hBADF_ABAC, 1'b0};
      vt[4]  = '{1'b1, 7'h03, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
      vt[5]  = '{1'b0, 7'h03, 32'h0,         4'hF, 32'hBADF_ABAC, 1'b0};
      vt[6]  = '{1'b0, 7'h20, 32'h0,         4'hF, 32'hBADF_ABAC, 1'b0};
      vt[7]  = '{1'b1, 7'h15, 32'hAABB_CCDD, 4'h2, 32'h0,         1'b0};
      vt[8]  = '{1'b0, 7'h15, 32'h0,         4'hF, 32'h0000_CC00, 1'b0};
      vt[9]  = '{1'b1, 7'h15, 32'h1122_3344, 4'h9, 32'h0,         1'b0};
      vt[10] = '{1'b0, 7'h15, 32'h0,         4'hF, 32'h1100_CC44, 1'b0};
      vt[11] = '{1'b1, 7'h11, 32'h5,         4'hF, 32'h0,         1'b0};
      vt[12] = '{1'b0, 7'h11, 32'h0,         4'hF, 32'h5,         1'b0};
      vt[13] = '{1'b1, 7'h13, 32'hFFFF_FFFE, 4'hF, 32'h0,         1'b0};
      vt[14] = '{1'b0, 7'h13, 32'h0,         4'hF, 32'hFFFF_FFFE, 1'b0};
      vt[15] = '{1'b0, 7'h10, 32'h0,         4'hF, 32'h0,         1'b0};
      vt[16] = '{1'b0, 7'h01, 32'h0,         4'hF, 32'h1,         1'b0};
      vt[17] = '{1'b1, 7'h02, 32'h1,         4'hF, 32'h0,         1'b1};
      vt[18] = '{1'b0, 7'h02, 32'h0,         4'hF, 32'h1,         1'b1};
      vt[19] = '{1'b1, 7'h01, 32'h1,         4'hF, 32'h0,         1'b0};
      vt[20] = '{1'b0, 7'h01, 32'h0,         4'hF, 32'h0,         1'b0};

      rst1 = 1'b0;
      rst2 = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 7'h0, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 1'b0, 7'h0, 32'h0, 4'h0);
      repeat (3) @(negedge clk);
      chk("rst_ack", {31'b0, bif1.WBs_ACK}, 32'h0);
      chk("rst_rd_dat", bif1.WBs_RD_DAT, 32'h0);
      chk("rst_count", cnt1[31:0] | cnt1[63:32] | cnt1[95:64] | cnt1[127:96], 32'h0);
      chk("rst_match_pulse", {26'b0, mp2, mp1}, 32'h0);
      chk("rst_irq", {30'b0, irq2, irq1}, 32'h0);
      rst1 = 1'b1;
      rst2 = 1'b1;

      // ID, unmapped, byte lanes, ch0 setup
      run_vecs(0, 16);

      // ch0 up-count through terminal into RELOAD
      wr(1'b0, 7'h10, 32'h1);
      chk("t2_cnt0", cnt1[31:0], 32'hFFFF_FFFE);
      @(negedge clk);
      chk("t2_cnt1", cnt1[31:0], 32'hFFFF_FFFF);
      @(negedge clk);
      chk("t2_cnt2", cnt1[31:0], 32'h5);
      @(negedge clk);
      chk("t2_cnt3", cnt1[31:0], 32'h6);

      // STATUS, IRQ_EN, irq level, W1C
      run_vecs(16, 21);

      // ch1 one-shot down-count holds at 0 and drops EN
      seq3 = '{32'h2, 32'h1, 32'h0, 32'h0, 32'h0};
      wr(1'b0, 7'h17, 32'h3);
      wr(1'b0, 7'h14, 32'h7);
      chk("t3_cnt_start", cnt1[63:32], 32'h3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("t3_cnt%0d", k), cnt1[63:32], seq3[k]);
      end
      rdchk(1'b0, 7'h14, 32'h6, "t3_ctrl");
      rdchk(1'b0, 7'h01, 32'h0000_0202, "t3_status");

      // ch2 compare pulse
      wr(1'b0, 7'h1A, 32'd10);
      wr(1'b0, 7'h1B, 32'h0);
      wr(1'b0, 7'h18, 32'h1);
      pulses = 0;
      at = 32'h0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (mp1[2]) begin
            pulses++;
            at = cnt1[95:64];
         end
      end
      chk("t4_pulse_count", 32'(pulses), 32'h1);
      chk("t4_pulse_at", at, 32'd11);
      rdchk(1'b0, 7'h01, 32'h0000_0602, "t4_status");
      chk("t4_irq", {31'b0, irq1}, 32'h0);

      // ch3: CLR collides with terminal count
      wr(1'b0, 7'h01, 32'hFFFF_FFFF);
      rdchk(1'b0, 7'h01, 32'h0, "t5_status_clear");
      wr(1'b0, 7'h1D, 32'd100);
      wr(1'b0, 7'h1E, 32'd50);
      wr(1'b0, 7'h1F, 32'h1);
      wr(1'b0, 7'h1C, 32'h3);
      wr(1'b0, 7'h1C, 32'h8);
      chk("t5_clr_cnt", cnt1[127:96], 32'h0);
      rdchk(1'b0, 7'h01, 32'h8, "t5_clr_ovf");
      rdchk(1'b0, 7'h1C, 32'h0, "t5_ctrl_after_clr");

      // ch3: W1C collides with OVF set
      wr(1'b0, 7'h01, 32'hFFFF_FFFF);
      rdchk(1'b0, 7'h01, 32'h0, "t5_status_clear2");
      wr(1'b0, 7'h1F, 32'h1);
      wr(1'b0, 7'h1C, 32'h3);
      wr(1'b0, 7'h01, 32'h8);
      rdchk(1'b0, 7'h01, 32'h8, "t5_w1c_collide");
      wr(1'b0, 7'h1C, 32'h0);

      // Narrow 2-channel 8-bit build
      rdchk(1'b1, 7'h00, 32'hC0B4_0001, "t6_id");
      wr(1'b1, 7'h13, 32'h1234);
      rdchk(1'b1, 7'h13, 32'h34, "t6_value_trunc");
      rdchk(1'b1, 7'h18, 32'hBADF_ABAC, "t6_unmapped_ch2");
      wr(1'b1, 7'h11, 32'h20);
      wr(1'b1, 7'h13, 32'hFE);
      wr(1'b1, 7'h10, 32'h1);
      chk("t6_cnt0", {16'b0, cnt2}, 32'h00FE);
      @(negedge clk);
      chk("t6_cnt1", {16'b0, cnt2}, 32'h00FF);
      @(negedge clk);
      chk("t6_cnt2", {16'b0, cnt2}, 32'h0020);
      rdchk(1'b1, 7'h01, 32'h1, "t6_status");
      wr(1'b1, 7'h02, 32'hFFFF_FFFF);
      rdchk(1'b1, 7'h02, 32'h0303, "t6_irq_en_mask");
      chk("t6_irq", {31'b0, irq2}, 32'h1);

      // Reset in the middle of a read
      drive(1'b1, 1'b1, 1'b0, 7'h11, 32'h0, 4'hF);
      #2 rst2 = 1'b0;
      @(negedge clk);
      chk("t6_rst_ack", {31'b0, bif2.WBs_ACK}, 32'h0);
      chk("t6_rst_rd_dat", bif2.WBs_RD_DAT, 32'h0);
      chk("t6_rst_cnt", {16'b0, cnt2}, 32'h0);
      chk("t6_rst_irq", {30'b0, mp2[0], irq2}, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 7'h0, 32'h0, 4'h0);
      @(negedge clk);
      rst2 = 1'b1;
      rdchk(1'b1, 7'h11, 32'h0, "t6_rst_reload");
      rdchk(1'b1, 7'h10, 32'h0, "t6_rst_ctrl");
      rdchk(1'b1, 7'h01, 32'h0, "t6_rst_status");
      rdchk(1'b1, 7'h02, 32'h0, "t6_rst_irq_en");
      chk("t6_rst_cnt_hold", {16'b0, cnt2}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
